// File: rtl/uart_tx_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_master
// Description : UART transmitter with a one-entry holding buffer that allows
//               back-to-back frames (start, D0..D7, optional even parity, stop).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_master #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       en_tx,
    output logic       tx_ready,
    output logic       u_tx,
    output logic       u_tx_busy,
    output logic       u_tx_done
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_PRE = c_CNT_W'(CLKS_PER_BIT - 2);
    localparam logic c_ONE_CLK = (CLKS_PER_BIT == 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [7:0]         r_buf;
    logic               r_buf_full;
    logic               r_ready;
    logic               r_tx;
    logic               r_done;

    logic w_bit_end;
    logic w_accept;
    logic w_stop_end;

    assign w_bit_end  = (r_clk_cnt == c_CNT_MAX);
    assign w_accept   = en_tx && r_ready;
    assign w_stop_end = (r_state == c_ST_STOP) && w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
            r_buf      <= 8'd0;
            r_buf_full <= 1'b0;
            r_ready    <= 1'b1;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            // Ready lags the buffer by one cycle so a drain never re-opens it early.
            r_ready <= !r_buf_full;

            if (r_state == c_ST_IDLE || w_bit_end) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + c_CNT_W'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_shift  <= data_in;
                        r_parity <= ^data_in;
                        r_tx     <= 1'b0;
                        r_state  <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= 3'd0;
                        r_state   <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= c_ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_done  <= c_ONE_CLK;
                                r_state <= c_ST_STOP;
                            end
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_done  <= c_ONE_CLK;
                        r_state <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (!c_ONE_CLK && !w_bit_end && r_clk_cnt == c_CNT_PRE) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (r_buf_full) begin
                            r_shift    <= r_buf;
                            r_parity   <= ^r_buf;
                            r_buf_full <= 1'b0;
                            r_tx       <= 1'b0;
                            r_state    <= c_ST_START;
                        end else if (w_accept) begin
                            r_shift  <= data_in;
                            r_parity <= ^data_in;
                            r_tx     <= 1'b0;
                            r_state  <= c_ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase

            // A request landing on the final stop clock goes straight to the shifter.
            if (w_accept && r_state != c_ST_IDLE && !w_stop_end) begin
                r_buf      <= data_in;
                r_buf_full <= 1'b1;
                r_ready    <= 1'b0;
            end
        end
    end

    assign tx_ready  = r_ready;
    assign u_tx      = r_tx;
    assign u_tx_busy = (r_state != c_ST_IDLE);
    assign u_tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_master
// Description : Directed self-checking bench for uart_tx_master (default and
//               CLKS_PER_BIT=4 / no-parity instances) with an expected-line queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       en_a, en_b;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    logic q_tx_a[$];
    logic q_done_a[$];
    logic q_tx_b[$];
    logic q_done_b[$];

    always #5 clk = ~clk;

    uart_tx_master #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .en_tx(en_a),
        .tx_ready(ready_a), .u_tx(tx_a), .u_tx_busy(busy_a), .u_tx_done(done_a)
    );

    uart_tx_master #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .en_tx(en_b),
        .tx_ready(ready_b), .u_tx(tx_b), .u_tx_busy(busy_b), .u_tx_done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line waveform: one entry per clk, done only on the final stop clock.
    task automatic push_frame(input int which, input logic [7:0] d);
        logic bits[$];
        int   cpb;
        int   ones;
        bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (which == 0) bits.push_back(ones % 2 == 1);
        bits.push_back(1'b1);
        cpb = (which == 0) ? 1 : 4;
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < cpb; c++) begin
                if (which == 0) begin
                    q_tx_a.push_back(bits[j]);
                    q_done_a.push_back(j == bits.size() - 1 && c == cpb - 1);
                end else begin
                    q_tx_b.push_back(bits[j]);
                    q_done_b.push_back(j == bits.size() - 1 && c == cpb - 1);
                end
            end
        end
    endtask

    task automatic tick();
        logic et, ed;
        @(negedge clk);
        if (q_tx_a.size() > 0) begin
            et = q_tx_a.pop_front();
            ed = q_done_a.pop_front();
            chk("a_busy", 32'(busy_a), 32'd1);
        end else begin
            et = 1'b1;
            ed = 1'b0;
            chk("a_busy", 32'(busy_a), 32'd0);
        end
        chk("a_tx", 32'(tx_a), 32'(et));
        chk("a_done", 32'(done_a), 32'(ed));
        if (q_tx_b.size() > 0) begin
            et = q_tx_b.pop_front();
            ed = q_done_b.pop_front();
            chk("b_busy", 32'(busy_b), 32'd1);
        end else begin
            et = 1'b1;
            ed = 1'b0;
            chk("b_busy", 32'(busy_b), 32'd0);
        end
        chk("b_tx", 32'(tx_b), 32'(et));
        chk("b_done", 32'(done_b), 32'(ed));
    endtask

    task automatic send_a(input logic [7:0] d);
        data_a = d;
        en_a   = 1'b1;
        push_frame(0, d);
        tick();
        en_a = 1'b0;
    endtask

    initial begin
        logic [7:0] corners [4];
        logic [7:0] rb;
        corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h01; corners[3] = 8'h80;

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        tick();
        tick();
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_ready_b", 32'(ready_b), 32'd1);
        rst = 1'b0;
        tick();

        // T1: A5 frame, ready stays high throughout
        send_a(8'hA5);
        chk("t1_ready", 32'(ready_a), 32'd1);
        repeat (10) tick();
        chk("t1_ready_end", 32'(ready_a), 32'd1);
        tick();

        // T2: parity corners
        foreach (corners[n]) begin
            send_a(corners[n]);
            repeat (11) tick();
        end

        // T3/T4: buffered C3, ignored 55 while full, ignored request at drain edge
        send_a(8'h3C);                    // cycle k+1
        tick();                           // k+2
        tick();                           // k+3
        data_a = 8'hC3; en_a = 1'b1;
        push_frame(0, 8'hC3);
        tick();                           // k+4
        en_a = 1'b0;
        chk("t3_ready_full", 32'(ready_a), 32'd0);
        data_a = 8'h55; en_a = 1'b1;
        tick();                           // k+5
        en_a = 1'b0;
        chk("t4_ready_full", 32'(ready_a), 32'd0);
        repeat (6) tick();                // k+11, last stop clock
        data_a = 8'h55; en_a = 1'b1;      // sampled at the drain edge
        tick();                           // k+12, second start bit
        en_a = 1'b0;
        chk("t3_ready_k12", 32'(ready_a), 32'd0);
        tick();                           // k+13
        chk("t3_ready_k13", 32'(ready_a), 32'd1);
        repeat (9) tick();                // k+22, second done
        repeat (3) tick();

        // T5: reset during D4 with a buffered byte
        send_a(8'h96);                    // k+1
        data_a = 8'h77; en_a = 1'b1;
        tick();                           // k+2
        en_a = 1'b0;
        tick();                           // k+3
        chk("t5_ready_full", 32'(ready_a), 32'd0);
        repeat (3) tick();                // k+6, D4
        rst = 1'b1;
        q_tx_a.delete();
        q_done_a.delete();
        tick();
        rst = 1'b0;
        chk("t5_ready_rst", 32'(ready_a), 32'd1);
        repeat (14) tick();

        // T6: slow no-parity instance, then random bytes on both
        data_b = 8'h81; en_b = 1'b1;
        push_frame(1, 8'h81);
        tick();
        en_b = 1'b0;
        repeat (40) tick();
        for (int r = 0; r < 3; r++) begin
            rb = 8'($urandom_range(0, 255));
            data_b = rb; en_b = 1'b1;
            push_frame(1, rb);
            send_a(8'($urandom_range(0, 255)));
            en_b = 1'b0;
            repeat (40) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
